pc_unit: RTL and testbench



---
 rtl/cpu_pkg.sv | 19 +
 rtl/ret_stack.sv | 68 ++++++
 rtl/pc_unit.sv | 116 +++++++++++
 tb/tb_pc_unit.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: next-PC operation encoding used by the control FSM
// and the program-counter unit.
package cpu_pkg;

   localparam int PC_W_DEF = 12;

   typedef enum logic [1:0] {
      PC_SEQ = 2'b00,
      PC_JMP = 2'b01,
      PC_RET = 2'b10,
      PC_BR  = 2'b11
   } pc_oper_e;

   // Sign-extend an 8-bit branch displacement; callers truncate to PC width.
   function automatic logic [31:0] sext8(input logic [7:0] v);
      return {{24{v[7]}}, v};
   endfunction

endpackage

// File: rtl/ret_stack.sv
// Hardware return-address LIFO with registered pointer and status flags;
// over/underflow are single-cycle pulses and the offending operation is dropped.
module ret_stack #(
   parameter int W     = 12,
   parameter int DEPTH = 8
) (
   input  logic         clk_i,
   input  logic         rst_ni,
   input  logic         push_i,
   input  logic         pop_i,
   input  logic [W-1:0] data_i,
   output logic [W-1:0] top_o,
   output logic         full_o,
   output logic         empty_o,
   output logic         overflow_o,
   output logic         underflow_o
);

   localparam int AW  = $clog2(DEPTH);
   localparam int SPW = AW + 1;
   localparam logic [SPW-1:0] SP_FULL = SPW'(DEPTH);

   logic [W-1:0]   mem_q [DEPTH];
   logic [SPW-1:0] sp_q, sp_d;
   logic           full_q, empty_q;
   logic           do_push_s, do_pop_s;
   logic [AW-1:0]  top_idx_s;

   always_comb begin
      do_push_s = push_i & ~full_q;
      do_pop_s  = pop_i & ~empty_q;
      sp_d      = sp_q;
      if (do_push_s) begin
         sp_d = sp_q + SPW'(1);
      end else if (do_pop_s) begin
         sp_d = sp_q - SPW'(1);
      end else begin
         sp_d = sp_q;
      end
   end

   // Index wraps naturally: with sp == DEPTH the low bits are zero, top is DEPTH-1.
   assign top_idx_s   = sp_q[AW-1:0] - AW'(1);
   assign top_o       = mem_q[top_idx_s];
   assign full_o      = full_q;
   assign empty_o     = empty_q;
   assign overflow_o  = push_i & full_q;
   assign underflow_o = pop_i & empty_q;

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         sp_q    <= '0;
         full_q  <= 1'b0;
         empty_q <= 1'b1;
      end else begin
         sp_q    <= sp_d;
         full_q  <= (sp_d == SP_FULL);
         empty_q <= (sp_d == '0);
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_ni && do_push_s) begin
         mem_q[sp_q[AW-1:0]] <= data_i;
      end
   end

endmodule

// File: rtl/pc_unit.sv
// Program-counter unit: next-PC selection, return-address stack and
// single-level interrupt entry/return with a saved return PC.
module pc_unit
   import cpu_pkg::*;
#(
   parameter int PC_W        = PC_W_DEF,
   parameter int STACK_DEPTH = 8,
   parameter int RESET_VEC   = 0,
   parameter int INT_VEC     = 1
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            pc_en_i,
   input  logic [1:0]      pc_oper_i,
   input  logic            jsb_i,
   input  logic            branch_taken_i,
   input  logic [PC_W-1:0] target_i,
   input  logic [7:0]      disp_i,
   input  logic            int_ack_i,
   input  logic            reti_i,
   output logic [PC_W-1:0] pc_o,
   output logic            int_active_o,
   output logic            stack_empty_o,
   output logic            stack_full_o,
   output logic            stack_err_o
);

   logic [PC_W-1:0] pc_q, pc_d, saved_q, saved_d;
   logic            int_active_q, int_active_d, err_q, err_d;
   logic [PC_W-1:0] pc_inc_s, next_pc_s, stk_top_s;
   logic            push_s, pop_s, entry_s, nest_s, iret_s, step_s;
   logic            stk_full_s, stk_empty_s, stk_ovf_s, stk_unf_s;

   assign pc_inc_s = pc_q + PC_W'(1);

   always_comb begin
      next_pc_s = pc_inc_s;
      push_s    = 1'b0;
      pop_s     = 1'b0;
      case (pc_oper_e'(pc_oper_i))
         PC_SEQ: next_pc_s = pc_inc_s;
         PC_JMP: begin
            next_pc_s = target_i;
            push_s    = jsb_i;
         end
         PC_RET: begin
            pop_s     = 1'b1;
            next_pc_s = stk_empty_s ? pc_inc_s : stk_top_s;
         end
         PC_BR:   next_pc_s = branch_taken_i ? pc_inc_s + PC_W'(sext8(disp_i)) : pc_inc_s;
         default: next_pc_s = pc_inc_s;
      endcase
   end

   // A nested int_ack is only an error; the same cycle's reti is then ignored.
   assign entry_s = int_ack_i & ~int_active_q;
   assign nest_s  = int_ack_i & int_active_q;
   assign iret_s  = reti_i & int_active_q & ~int_ack_i;
   assign step_s  = pc_en_i & ~iret_s;

   ret_stack #(
      .W     (PC_W),
      .DEPTH (STACK_DEPTH)
   ) u_ret_stack (
      .clk_i       (clk),
      .rst_ni      (rst),
      .push_i      (step_s & push_s),
      .pop_i       (step_s & pop_s),
      .data_i      (pc_inc_s),
      .top_o       (stk_top_s),
      .full_o      (stk_full_s),
      .empty_o     (stk_empty_s),
      .overflow_o  (stk_ovf_s),
      .underflow_o (stk_unf_s)
   );

   always_comb begin
      pc_d         = pc_q;
      saved_d      = saved_q;
      int_active_d = int_active_q;
      err_d        = err_q | nest_s | stk_ovf_s | stk_unf_s;
      if (entry_s) begin
         saved_d      = pc_en_i ? next_pc_s : pc_q;
         pc_d         = PC_W'(INT_VEC);
         int_active_d = 1'b1;
      end else if (iret_s) begin
         pc_d         = saved_q;
         int_active_d = 1'b0;
      end else if (step_s) begin
         pc_d = next_pc_s;
      end else begin
         pc_d = pc_q;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         pc_q         <= PC_W'(RESET_VEC);
         saved_q      <= '0;
         int_active_q <= 1'b0;
         err_q        <= 1'b0;
      end else begin
         pc_q         <= pc_d;
         saved_q      <= saved_d;
         int_active_q <= int_active_d;
         err_q        <= err_d;
      end
   end

   assign pc_o          = pc_q;
   assign int_active_o  = int_active_q;
   assign stack_empty_o = stk_empty_s;
   assign stack_full_o  = stk_full_s;
   assign stack_err_o   = err_q;

endmodule

// File: tb/tb_pc_unit.sv
// Directed bench for pc_unit: a queue-based reference model checked every
// cycle, plus hand-computed PC/flag expectations from the test plan.
module tb_pc_unit;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        pc_en_i = 1'b0;
   logic [1:0]  pc_oper_i = 2'b00;
   logic        jsb_i = 1'b0;
   logic        branch_taken_i = 1'b0;
   logic [11:0] target_i = 12'h000;
   logic [7:0]  disp_i = 8'h00;
   logic        int_ack_i = 1'b0;
   logic        reti_i = 1'b0;
   logic [11:0] pc_o;
   logic        int_active_o, stack_empty_o, stack_full_o, stack_err_o;

   always #5 clk = ~clk;

   pc_unit #(
      .PC_W        (12),
      .STACK_DEPTH (8),
      .RESET_VEC   (0),
      .INT_VEC     (1)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .pc_en_i        (pc_en_i),
      .pc_oper_i      (pc_oper_i),
      .jsb_i          (jsb_i),
      .branch_taken_i (branch_taken_i),
      .target_i       (target_i),
      .disp_i         (disp_i),
      .int_ack_i      (int_ack_i),
      .reti_i         (reti_i),
      .pc_o           (pc_o),
      .int_active_o   (int_active_o),
      .stack_empty_o  (stack_empty_o),
      .stack_full_o   (stack_full_o),
      .stack_err_o    (stack_err_o)
   );

   // Reference model state
   logic [11:0] m_pc = 12'h000;
   logic [11:0] m_saved = 12'h000;
   bit          m_act = 1'b0;
   bit          m_err = 1'b0;
   logic [11:0] m_stack[$];
   bit          chk_en = 1'b0;

   int          n_cmp = 0;
   int          n_bad = 0;

   int          lit_seq = 0;
   int          lit_seen = 0;
   string       lit_name = "";
   int          lit_sel = 0;
   logic [11:0] lit_exp = 12'h000;

   task automatic cmp(input string name, input logic [11:0] act, input logic [11:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      logic [11:0] a;
      if (chk_en) begin
         cmp("pc", pc_o, m_pc);
         cmp("int_active", {11'd0, int_active_o}, {11'd0, m_act});
         cmp("stack_empty", {11'd0, stack_empty_o}, {11'd0, (m_stack.size() == 0)});
         cmp("stack_full", {11'd0, stack_full_o}, {11'd0, (m_stack.size() == 8)});
         cmp("stack_err", {11'd0, stack_err_o}, {11'd0, m_err});
      end
      if (lit_seq != lit_seen) begin
         lit_seen = lit_seq;
         case (lit_sel)
            0:       a = pc_o;
            1:       a = {11'd0, stack_err_o};
            2:       a = {11'd0, int_active_o};
            3:       a = {11'd0, stack_empty_o};
            default: a = {11'd0, stack_full_o};
         endcase
         cmp(lit_name, a, lit_exp);
      end
   end

   task automatic expect_lit(input string name, input int sel, input logic [11:0] exp);
      lit_name = name;
      lit_sel  = sel;
      lit_exp  = exp;
      lit_seq++;
      @(negedge clk);
      #1;
   endtask

   task automatic idle();
      pc_en_i = 1'b0; pc_oper_i = 2'b00; jsb_i = 1'b0; branch_taken_i = 1'b0;
      target_i = 12'h000; disp_i = 8'h00; int_ack_i = 1'b0; reti_i = 1'b0;
   endtask

   task automatic step(input bit en, input logic [1:0] op, input bit jsb, input bit tk,
                       input logic [11:0] tgt, input logic [7:0] d, input bit ack, input bit rt);
      logic [11:0] inc, nxt;
      bit entry, ret_ok;
      pc_en_i = en; pc_oper_i = op; jsb_i = jsb; branch_taken_i = tk;
      target_i = tgt; disp_i = d; int_ack_i = ack; reti_i = rt;
      inc = m_pc + 12'd1;
      case (op)
         2'b00:   nxt = inc;
         2'b01:   nxt = tgt;
         2'b10:   nxt = (m_stack.size() == 0) ? inc : m_stack[$];
         default: nxt = tk ? inc + {{4{d[7]}}, d} : inc;
      endcase
      @(posedge clk);
      #1;
      entry  = ack && !m_act;
      ret_ok = rt && m_act && !ack;
      if (ack && m_act) m_err = 1'b1;
      if (en && !ret_ok) begin
         if (op == 2'b01 && jsb) begin
            if (m_stack.size() == 8) m_err = 1'b1;
            else m_stack.push_back(inc);
         end
         if (op == 2'b10) begin
            if (m_stack.size() == 0) m_err = 1'b1;
            else void'(m_stack.pop_back());
         end
      end
      if (entry) begin
         m_saved = en ? nxt : m_pc;
         m_pc    = 12'h001;
         m_act   = 1'b1;
      end else if (ret_ok) begin
         m_pc  = m_saved;
         m_act = 1'b0;
      end else if (en) begin
         m_pc = nxt;
      end
      idle();
   endtask

   task automatic seq_op();                    step(1'b1, 2'b00, 1'b0, 1'b0, 12'h000, 8'h00, 1'b0, 1'b0); endtask
   task automatic jmp(input logic [11:0] t);   step(1'b1, 2'b01, 1'b0, 1'b0, t, 8'h00, 1'b0, 1'b0); endtask
   task automatic call(input logic [11:0] t);  step(1'b1, 2'b01, 1'b1, 1'b0, t, 8'h00, 1'b0, 1'b0); endtask
   task automatic ret_op();                    step(1'b1, 2'b10, 1'b0, 1'b0, 12'h000, 8'h00, 1'b0, 1'b0); endtask
   task automatic br(input bit tk, input logic [7:0] d); step(1'b1, 2'b11, 1'b0, tk, 12'h000, d, 1'b0, 1'b0); endtask

   // Reset asserted while every strobe is active: reset must win.
   task automatic do_reset();
      rst = 1'b0; pc_en_i = 1'b1; pc_oper_i = 2'b01; jsb_i = 1'b1;
      target_i = 12'h3AB; int_ack_i = 1'b1; reti_i = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b1;
      idle();
      m_pc = 12'h000; m_saved = 12'h000; m_act = 1'b0; m_err = 1'b0;
      m_stack.delete();
      chk_en = 1'b1;
   endtask

   initial begin
      idle();
      do_reset();
      expect_lit("reset_pc", 0, 12'h000);
      expect_lit("reset_empty", 3, 12'h001);
      for (int i = 1; i <= 3; i++) begin
         seq_op();
         expect_lit("seq_pc", 0, 12'(i));
      end

      jmp(12'hFFF);
      seq_op();
      expect_lit("wrap_pc", 0, 12'h000);
      expect_lit("wrap_no_err", 1, 12'h000);

      jmp(12'h010); br(1'b1, 8'hFC);
      expect_lit("br_taken", 0, 12'h00D);
      jmp(12'h010); br(1'b0, 8'hFC);
      expect_lit("br_not_taken", 0, 12'h011);
      jmp(12'h002); br(1'b1, 8'h80);
      expect_lit("br_wrap", 0, 12'hF83);

      jmp(12'h020); call(12'h100);
      expect_lit("call_pc", 0, 12'h100);
      ret_op();
      expect_lit("ret_pc", 0, 12'h021);
      expect_lit("ret_empty", 3, 12'h001);

      jmp(12'h1F0);
      for (int i = 0; i < 9; i++) begin
         call(12'h200 + 12'(i * 16));
         if (i == 7) begin
            expect_lit("full_after_8", 4, 12'h001);
            expect_lit("no_err_at_8", 1, 12'h000);
         end
      end
      expect_lit("ovf_jump_taken", 0, 12'h280);
      expect_lit("ovf_err", 1, 12'h001);
      for (int i = 0; i < 8; i++) ret_op();
      expect_lit("unwind_pc", 0, 12'h1F1);
      expect_lit("unwind_empty", 3, 12'h001);

      do_reset();
      expect_lit("reset_clears_err", 1, 12'h000);
      jmp(12'h050); ret_op();
      expect_lit("unf_pc", 0, 12'h051);
      expect_lit("unf_err", 1, 12'h001);

      do_reset();
      jmp(12'h030);
      step(1'b1, 2'b00, 1'b0, 1'b0, 12'h000, 8'h00, 1'b1, 1'b0);
      expect_lit("int_pc", 0, 12'h001);
      expect_lit("int_active", 2, 12'h001);
      step(1'b0, 2'b00, 1'b0, 1'b0, 12'h000, 8'h00, 1'b1, 1'b0);
      expect_lit("nest_err", 1, 12'h001);
      expect_lit("nest_pc_hold", 0, 12'h001);
      step(1'b1, 2'b00, 1'b0, 1'b0, 12'h000, 8'h00, 1'b0, 1'b1);
      expect_lit("reti_pc", 0, 12'h031);
      expect_lit("reti_inactive", 2, 12'h000);

      // Interrupt entry while a call pushes: push still lands, saved PC is the target.
      step(1'b1, 2'b01, 1'b1, 1'b0, 12'h400, 8'h00, 1'b1, 1'b0);
      ret_op();
      expect_lit("int_push_pop", 0, 12'h032);
      step(1'b0, 2'b00, 1'b0, 1'b0, 12'h000, 8'h00, 1'b0, 1'b1);
      expect_lit("reti_to_target", 0, 12'h400);
      repeat (3) @(posedge clk);
      #1;
      expect_lit("hold_pc", 0, 12'h400);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
